async_operator_fifo: RTL and testbench

Parametrised successor of the dataflow handshake operator used in generated `arf` graphs. It gathers one operand per input channel over a req/ack pull handshake, computes a configurable op, and queues the result in an internal result FIFO. Results are delivered to `output_size` consumers, each with an independent ack, so a slow consumer no longer stalls operand collection until the FIFO fills. Drop-in replacement for graph nodes where fan-out consumers run at different rates.

---
 rtl/async_operator_fifo_pkg.sv | 17 +
 rtl/async_operator_fifo_operator_alu.sv | 30 +++
 rtl/async_operator_fifo.sv | 82 ++++++++
 tb/tb_async_operator_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/async_operator_fifo_pkg.sv
// async_operator_fifo_pkg: op encodings, op-name lookup and size bounds shared by the operator FIFO.
package async_operator_fifo_pkg;
  typedef enum logic [3:0] {
    OP_REG, OP_IN, OP_OUT, OP_ADDI, OP_SUBI, OP_MULI, OP_ADD,
    OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_MIN, OP_MAX
  } op_e;
  localparam int max_input_size = 4;
  localparam int max_output_size = 8;
  localparam int max_fifo_depth = 16;
  function automatic op_e op_from_str(input string s);
    return s == "in"   ? OP_IN   : s == "out"  ? OP_OUT  : s == "addi" ? OP_ADDI :
           s == "subi" ? OP_SUBI : s == "muli" ? OP_MULI : s == "add"  ? OP_ADD  :
           s == "sub"  ? OP_SUB  : s == "mul"  ? OP_MUL  : s == "and"  ? OP_AND  :
           s == "or"   ? OP_OR   : s == "xor"  ? OP_XOR  : s == "min"  ? OP_MIN  :
           s == "max"  ? OP_MAX  : OP_REG;
  endfunction
endpackage

// File: rtl/async_operator_fifo_operator_alu.sv
// operator_alu: combinational reduction of the operand slots under the configured op.
module operator_alu
  import async_operator_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int input_size = 1,
  parameter op_e op = OP_REG,
  parameter int immediate = 0
) (
  input  logic [data_width*input_size-1:0] operands,
  output logic [data_width-1:0]            result
);
  localparam int pad_w = data_width * max_input_size;
  localparam logic [data_width-1:0] imm = data_width'(immediate);
  logic [pad_w-1:0] ops_p;
  logic [data_width-1:0] r, v;
  assign ops_p = pad_w'(operands);
  always_comb begin
    r = ops_p[data_width-1:0];
    v = '0;
    for (int g = 1; g < max_input_size; g++) begin
      v = ops_p[g*data_width +: data_width];
      if (g < input_size)
        r = op == OP_ADD ? r + v : op == OP_SUB ? r - v : op == OP_MUL ? r * v :
            op == OP_AND ? r & v : op == OP_OR  ? r | v : op == OP_XOR ? r ^ v :
            op == OP_MIN ? (v < r ? v : r) : op == OP_MAX ? (v > r ? v : r) : r;
    end
    result = op == OP_ADDI ? r + imm : op == OP_SUBI ? r - imm : op == OP_MULI ? r * imm : r;
  end
endmodule

// File: rtl/async_operator_fifo.sv
// async_operator_fifo: pull-handshake operand gather, op, result FIFO with per-consumer delivery.
module async_operator_fifo
  import async_operator_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter string op = "reg",
  parameter int immediate = 0,
  parameter int input_size = 1,
  parameter int output_size = 1,
  parameter int fifo_depth = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic [input_size-1:0]                req_l,
  input  logic [input_size-1:0]                ack_l,
  input  logic [data_width*input_size-1:0]     din,
  input  logic [output_size-1:0]               req_r,
  output logic [output_size-1:0]               ack_r,
  output logic [data_width-1:0]                dout,
  output logic [31:0]                          count,
  output logic [$clog2(fifo_depth+1)-1:0]      occupancy,
  output logic                                 err
);
  localparam int ow = $clog2(fifo_depth + 1);
  localparam int pw = fifo_depth > 1 ? $clog2(fifo_depth) : 1;
  localparam logic [ow-1:0] depth_v = ow'(fifo_depth);
  logic [data_width*input_size-1:0] slots;
  logic [input_size-1:0] full, full_n;
  logic [data_width-1:0] mem [fifo_depth];
  logic [data_width-1:0] res, dout_n;
  logic [pw-1:0] rd, wr, rd_n;
  logic [ow-1:0] occ_n;
  logic [output_size-1:0] served, ack_n;
  logic push, pop;
  function automatic logic [pw-1:0] inc(input logic [pw-1:0] p);
    return p == pw'(fifo_depth - 1) ? '0 : p + pw'(1);
  endfunction
  operator_alu #(
    .data_width(data_width), .input_size(input_size),
    .op(op_from_str(op)), .immediate(immediate)
  ) u_alu (.operands(slots), .result(res));
  always_comb begin
    push = &full && occupancy < depth_v;
    pop = &served;
    full_n = push ? '0 : full | ack_l;
    ack_n = req_r & ~served & ~ack_r & {output_size{occupancy != '0 && !pop}};
    occ_n = occupancy + ow'(push) - ow'(pop);
    rd_n = pop ? inc(rd) : rd;
    // a value pushed into an otherwise-empty queue becomes the head immediately
    dout_n = occ_n == '0 ? '0 : push && rd_n == wr ? res : mem[rd_n];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= '0;
      req_l <= '0;
      ack_r <= '0;
      served <= '0;
      dout <= '0;
      count <= '0;
      occupancy <= '0;
      err <= 1'b0;
      rd <= '0;
      wr <= '0;
    end else begin
      for (int g = 0; g < input_size; g++)
        if (ack_l[g] && !full[g]) slots[g*data_width +: data_width] <= din[g*data_width +: data_width];
      full <= full_n;
      req_l <= ~full_n;
      err <= err | |(ack_l & full);
      if (push) begin
        mem[wr] <= res;
        wr <= inc(wr);
        count <= count + 32'd1;
      end
      rd <= rd_n;
      occupancy <= occ_n;
      served <= pop ? '0 : served | ack_n;
      ack_r <= ack_n;
      dout <= dout_n;
    end
  end
endmodule

// File: tb/tb_async_operator_fifo.sv
// tb_async_operator_fifo: vector table, hand sequences and randomized model checks over four configurations.
module tb_async_operator_fifo;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic [1:0] a_reql, a_ackl = 0;
  logic [63:0] a_din = 0;
  logic [0:0] a_reqr = 1, a_ackr;
  logic [31:0] a_dout, a_count;
  logic [1:0] a_occ;
  logic a_err;

  logic [0:0] s_reql, s_ackl = 0, s_reqr = 1, s_ackr;
  logic [31:0] s_din = 0, s_dout, s_count;
  logic [1:0] s_occ;
  logic s_err;

  logic [0:0] r_reql, r_ackl = 0;
  logic [1:0] r_reqr = 0, r_ackr;
  logic [31:0] r_din = 0, r_dout, r_count;
  logic [1:0] r_occ;
  logic r_err;

  logic [0:0] p_reql, p_ackl = 0, p_reqr = 1, p_ackr;
  logic [31:0] p_din = 0, p_dout, p_count;
  logic [1:0] p_occ;
  logic p_err;

  async_operator_fifo #(.data_width(32), .op("add"), .input_size(2), .output_size(1), .fifo_depth(2)) u_add (
    .clk(clk), .rst(rst), .req_l(a_reql), .ack_l(a_ackl), .din(a_din), .req_r(a_reqr),
    .ack_r(a_ackr), .dout(a_dout), .count(a_count), .occupancy(a_occ), .err(a_err));
  async_operator_fifo #(.data_width(32), .op("subi"), .immediate(3), .input_size(1), .output_size(1), .fifo_depth(2)) u_subi (
    .clk(clk), .rst(rst), .req_l(s_reql), .ack_l(s_ackl), .din(s_din), .req_r(s_reqr),
    .ack_r(s_ackr), .dout(s_dout), .count(s_count), .occupancy(s_occ), .err(s_err));
  async_operator_fifo #(.data_width(32), .op("reg"), .input_size(1), .output_size(2), .fifo_depth(2)) u_reg (
    .clk(clk), .rst(rst), .req_l(r_reql), .ack_l(r_ackl), .din(r_din), .req_r(r_reqr),
    .ack_r(r_ackr), .dout(r_dout), .count(r_count), .occupancy(r_occ), .err(r_err));
  async_operator_fifo #(.data_width(32), .op("addi"), .immediate(2), .input_size(1), .output_size(1), .fifo_depth(2)) u_addi (
    .clk(clk), .rst(rst), .req_l(p_reql), .ack_l(p_ackl), .din(p_din), .req_r(p_reqr),
    .ack_r(p_ackr), .dout(p_dout), .count(p_count), .occupancy(p_occ), .err(p_err));

  int checks = 0, failures = 0, cyc = 0;
  int r_idx [2];
  int p_got = 0, p_first = 0, p_last = 0;
  bit p_rand = 0;
  logic [31:0] r_in[$], r_src[$], p_src[$], p_exp[$];

  typedef struct {logic [31:0] a, b, add_exp, subi_exp;} vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one clock: observe post-edge outputs, then drive the model-controlled upstreams/consumers
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int j = 0; j < 2; j++)
      if (r_ackr[j]) begin
        check($sformatf("reg_dout_c%0d", j), r_dout, r_idx[j] < r_in.size() ? r_in[r_idx[j]] : 32'bx);
        r_idx[j]++;
      end
    if (p_ackr[0]) begin
      check("addi_dout", p_dout, p_exp.size() != 0 ? p_exp.pop_front() : 32'bx);
      p_got++;
      if (p_got == 1) p_first = cyc;
      p_last = cyc;
    end
    r_ackl = 0;
    if (r_reql[0] && r_src.size() != 0) begin
      r_din = r_src.pop_front();
      r_ackl = 1;
      r_in.push_back(r_din);
    end
    p_ackl = 0;
    if (p_reql[0] && p_src.size() != 0 && (!p_rand || $urandom_range(0, 1) == 1)) begin
      p_din = p_src.pop_front();
      p_ackl = 1;
      p_exp.push_back(p_din + 32'd2);
    end
    p_reqr = (!p_rand || $urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'd5, 32'd7, 32'd12, 32'd2};
    vecs[1] = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFE};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFC};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'd0, 32'h7FFF_FFFD};
    vecs[4] = '{32'h0000_1234, 32'h0000_0010, 32'h0000_1244, 32'h0000_1231};
    r_idx[0] = 0;
    r_idx[1] = 0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_req_l", a_reql, 0);
    check("rst_ack_r", {a_ackr, r_ackr}, 0);
    check("rst_dout", a_dout, 0);
    check("rst_count", a_count, 0);
    check("rst_occ", a_occ, 0);
    check("rst_err", a_err, 0);
    rst = 1;

    foreach (vecs[i]) begin
      for (int w = 0; w < 10 && !(a_reql == 2'b11 && s_reql == 1'b1); w++) tick();
      check("vec_req_ready", {a_reql, s_reql}, 3'b111);
      a_ackl = 2'b01; a_din = {32'd0, vecs[i].a}; s_ackl = 1; s_din = vecs[i].a;
      tick();
      check("add_req_l_after_cap0", a_reql, 2'b10);
      a_ackl = 2'b10; a_din = {vecs[i].b, 32'd0}; s_ackl = 0;
      tick();
      check("subi_push_dout", s_dout, vecs[i].subi_exp);
      check("subi_push_occ", s_occ, 1);
      check("subi_push_noack", s_ackr, 0);
      a_ackl = 0;
      tick();
      check("add_push_dout", a_dout, vecs[i].add_exp);
      check("add_push_occ", a_occ, 1);
      check("add_push_noack", a_ackr, 0);
      check("add_req_l_rearm", a_reql, 2'b11);
      check("add_count", a_count, i + 1);
      check("subi_ack", s_ackr, 1);
      check("subi_ack_dout", s_dout, vecs[i].subi_exp);
      tick();
      check("add_ack", a_ackr, 1);
      check("add_ack_dout", a_dout, vecs[i].add_exp);
      check("subi_pop_noack", s_ackr, 0);
      check("subi_pop_occ", s_occ, 0);
      check("subi_pop_dout", s_dout, 0);
      tick();
      check("add_pop_noack", a_ackr, 0);
      check("add_pop_occ", a_occ, 0);
      check("add_pop_dout", a_dout, 0);
    end

    check("err_clear", a_err, 0);
    a_ackl = 2'b01; a_din = {32'd0, 32'd10};
    tick();
    a_ackl = 2'b01; a_din = {32'd0, 32'd99};
    tick();
    check("err_set", a_err, 1);
    check("err_req_l", a_reql, 2'b10);
    a_ackl = 2'b10; a_din = {32'd20, 32'd0};
    tick();
    a_ackl = 0;
    tick();
    check("err_first_kept", a_dout, 30);
    for (int i = 0; i < 3; i++) tick();
    check("err_sticky", a_err, 1);

    r_src = '{32'd1, 32'd2, 32'd3};
    r_reqr = 2'b01;
    for (int i = 0; i < 10; i++) tick();
    check("reg_occ_full", r_occ, 2);
    check("reg_req_l_held", r_reql, 0);
    check("reg_c0_waits", r_idx[0], 1);
    check("reg_c1_none", r_idx[1], 0);
    r_reqr = 2'b11;
    for (int i = 0; i < 40 && !(r_idx[0] == 3 && r_idx[1] == 3); i++) tick();
    check("reg_c0_all", r_idx[0], 3);
    check("reg_c1_all", r_idx[1], 3);
    check("reg_count", r_count, 3);

    r_src = '{32'd4, 32'd5, 32'd6};
    r_reqr = 2'b01;
    for (int i = 0; i < 8; i++) tick();
    r_reqr = 2'b11;
    tick();
    check("pre_rst_ack", r_ackr, 2'b10);
    check("pre_rst_occ", r_occ, 2);
    r_src.delete();
    r_in.delete();
    r_idx[0] = 0;
    r_idx[1] = 0;
    rst = 0;
    r_ackl = 0;
    tick();
    check("mid_rst_req_l", r_reql, 0);
    check("mid_rst_ack_r", r_ackr, 0);
    check("mid_rst_dout", r_dout, 0);
    check("mid_rst_count", r_count, 0);
    check("mid_rst_occ", r_occ, 0);
    check("mid_rst_err", a_err, 0);
    rst = 1;
    r_src = '{32'd9};
    for (int i = 0; i < 20 && !(r_idx[0] == 1 && r_idx[1] == 1); i++) tick();
    check("post_rst_c0", r_idx[0], 1);
    check("post_rst_c1", r_idx[1], 1);
    check("post_rst_count", r_count, 1);

    for (int i = 0; i < 5000; i++) p_src.push_back($urandom);
    for (int t = 0; t < 10100 && p_got < 5000; t++) tick();
    check("stream_delivered", p_got, 5000);
    check("stream_count", p_count, 5000);
    check("stream_rate", p_last - p_first, 2 * 4999);
    check("stream_err", p_err, 0);

    p_rand = 1;
    for (int i = 0; i < 400; i++) p_src.push_back($urandom);
    for (int t = 0; t < 8000 && p_got < 5400; t++) tick();
    check("rand_delivered", p_got, 5400);
    check("rand_count", p_count, 5400);
    check("rand_err", p_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
